// File: rtl/time_entry_encoder_pkg.sv
// Shared types and constants for the pushbutton time-entry encoder.
// Holds the FSM state enum, buffer/result sizing and the digit-button encoder.
package time_entry_encoder_pkg;

  localparam int NDIG      = 4;
  localparam int VW        = 12;
  localparam int NIB_W     = 4;
  localparam int MAX_VALUE = 4095;
  localparam int NBTN      = 10;
  localparam int DIG_W     = NDIG * NIB_W;
  localparam int CNT_W     = 3;
  localparam int IDX_W     = 2;
  localparam int ACC_W     = 14;          // 9999 fits without wrap
  localparam int NRAW      = NBTN + 3;    // digits + enter + back + clear

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  // Index of the highest set digit button; only meaningful when one bit is set.
  function automatic logic [NIB_W-1:0] dig_enc(input logic [NBTN-1:0] p);
    logic [NIB_W-1:0] r;
    r = '0;
    for (int i = 0; i < NBTN; i++)
      if (p[i]) r = NIB_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector.
// pulse_o is high for one cycle per low-to-high transition of d_i.
module sync_edge_detect (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic pulse_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) sh_q <= '0;
    else       sh_q <= {sh_q[1:0], d_i};
  end

  assign pulse_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/time_entry_encoder.sv
// Collects up to four keyed BCD digits and converts them to a binary time value
// with one shift-and-add step per digit; overflow above MAX_VALUE is rejected.
module time_entry_encoder
  import time_entry_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NBTN-1:0]   pb_digit,
  input  logic              pb_enter,
  input  logic              pb_back,
  input  logic              pb_clear,
  output logic [DIG_W-1:0]  digits,
  output logic [CNT_W-1:0]  count,
  output logic [VW-1:0]     value,
  output logic              value_valid,
  output logic              entry_err,
  output logic              busy
);

  logic [NRAW-1:0] raw, prs;
  logic [NBTN-1:0] dig_p;
  logic            ent_p, back_p, clr_p;

  assign raw = {pb_clear, pb_back, pb_enter, pb_digit};

  for (genvar g = 0; g < NRAW; g++) begin : g_btn
    sync_edge_detect u_sed (
      .clk     (clk),
      .nrst    (~reset),
      .d_i     (raw[g]),
      .pulse_o (prs[g])
    );
  end

  assign dig_p  = prs[NBTN-1:0];
  assign ent_p  = prs[NBTN];
  assign back_p = prs[NBTN+1];
  assign clr_p  = prs[NBTN+2];

  state_e           state_q, state_d;
  logic [DIG_W-1:0] digits_q, digits_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [VW-1:0]    value_q, value_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_nx;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vv_q, vv_d, err_q, err_d;
  logic [NIB_W-1:0] nib;
  logic             dig_multi;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign dig_multi = |(dig_p & (dig_p - NBTN'(1)));
  assign nib       = digits_q[idx_q*NIB_W +: NIB_W];
  assign acc_nx    = (acc_q << 3) + (acc_q << 1) + ACC_W'(nib);

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    value_d  = value_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    vv_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_p) begin
          digits_d = '0;
          count_d  = '0;
        end else if (back_p) begin
          if (count_q != '0) begin
            digits_d = digits_q >> NIB_W;
            count_d  = count_q - CNT_W'(1);
          end
        end else if (ent_p) begin
          acc_d   = '0;
          idx_d   = IDX_W'(NDIG - 1);
          state_d = CONV;
        end else if (|dig_p) begin
          if (dig_multi || count_q == CNT_W'(NDIG)) begin
            err_d = 1'b1;
          end else begin
            digits_d = {digits_q[DIG_W-NIB_W-1:0], dig_enc(dig_p)};
            count_d  = count_q + CNT_W'(1);
          end
        end
      end
      CONV: begin
        acc_d = acc_nx;
        idx_d = idx_q - IDX_W'(1);
        // Result is registered on the final step so value and its pulse land in DONE.
        if (idx_q == '0) begin
          state_d = DONE;
          if (acc_nx <= ACC_W'(MAX_VALUE)) begin
            value_d = acc_nx[VW-1:0];
            vv_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        digits_d = '0;
        count_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      digits_q <= '0;
      count_q  <= '0;
      value_q  <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      vv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      value_q  <= value_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      vv_q     <= vv_d;
      err_q    <= err_d;
    end
  end

  assign digits      = digits_q;
  assign count       = count_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign entry_err   = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_time_entry_encoder.sv
// Directed bench for time_entry_encoder: pulses are checked against a queue of
// expected events pushed when the stimulus that causes them is driven.
module tb_time_entry_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pb_digit = '0;
  logic        pb_enter = 1'b0, pb_back = 1'b0, pb_clear = 1'b0;
  logic [15:0] digits;
  logic [2:0]  count;
  logic [11:0] value;
  logic        value_valid, entry_err, busy;

  typedef struct { logic err; logic [11:0] val; } ev_t;
  ev_t sb[$];

  int tests = 0, fails = 0;
  logic [11:0] exp_value = '0;

  time_entry_encoder dut (
    .clk(clk), .reset(reset), .pb_digit(pb_digit), .pb_enter(pb_enter),
    .pb_back(pb_back), .pb_clear(pb_clear), .digits(digits), .count(count),
    .value(value), .value_valid(value_valid), .entry_err(entry_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every value_valid / entry_err pulse must match a queued event.
  always @(negedge clk) begin
    if (value_valid || entry_err) begin
      chk("pulse_exclusive", {31'b0, value_valid & entry_err}, 32'd0);
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_pulse observed vv=%0b err=%0b expected none", value_valid, entry_err);
      end
      if (sb.size() != 0) begin
        ev_t e;
        e = sb.pop_front();
        chk("sb_kind", {31'b0, entry_err}, {31'b0, e.err});
        chk("sb_value", {20'b0, value}, {20'b0, e.val});
      end
    end
  end

  // Hold the raw buttons two cycles, release, then let sync + update settle.
  task automatic press(input logic [9:0] d, input logic bk, input logic cl);
    @(negedge clk);
    pb_digit = d; pb_back = bk; pb_clear = cl;
    repeat (2) @(negedge clk);
    pb_digit = '0; pb_back = 1'b0; pb_clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic key(input int d);
    logic [9:0] m;
    m = '0;
    m[d] = 1'b1;
    press(m, 1'b0, 1'b0);
  endtask

  task automatic wait_busy();
    for (int k = 0; k < 10 && !busy; k++) @(negedge clk);
    chk("busy_rise", {31'b0, busy}, 32'd1);
  endtask

  // Enter, then measure busy length and the busy cycle carrying the result pulse.
  task automatic enter(input logic ok, input logic [11:0] v, input logic dig_during);
    int n, pn;
    ev_t e;
    e.err = ~ok;
    e.val = ok ? v : exp_value;
    sb.push_back(e);
    if (ok) exp_value = v;
    @(negedge clk);
    pb_enter = 1'b1;
    repeat (2) @(negedge clk);
    pb_enter = 1'b0;
    wait_busy();
    n = 0; pn = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      n++;
      if (value_valid || entry_err) pn = n;
      if (dig_during && n == 1) pb_digit[5] = 1'b1;
      if (n == 3) pb_digit = '0;
      @(negedge clk);
    end
    chk("busy_len", n, 5);
    chk("pulse_cycle", pn, 5);
    repeat (3) @(negedge clk);
    chk("post_digits", {16'b0, digits}, 32'd0);
    chk("post_count", {29'b0, count}, 32'd0);
    chk("post_value", {20'b0, value}, {20'b0, exp_value});
  endtask

  initial begin
    ev_t e;
    repeat (3) @(negedge clk);
    chk("rst_digits", {16'b0, digits}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_value", {20'b0, value}, 32'd0);
    chk("rst_vv", {31'b0, value_valid}, 32'd0);
    chk("rst_err", {31'b0, entry_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1234 converts normally
    key(1); key(2); key(3); key(4);
    chk("buf_1234", {16'b0, digits}, 32'h1234);
    chk("cnt_4", {29'b0, count}, 32'd4);
    enter(1'b1, 12'd1234, 1'b0);

    // 4096 overflows by one
    key(4); key(0); key(9); key(6);
    enter(1'b0, 12'd0, 1'b0);

    // 4095 is the largest accepted value
    key(4); key(0); key(9); key(5);
    enter(1'b1, 12'd4095, 1'b0);

    // 9999 overflows
    key(9); key(9); key(9); key(9);
    enter(1'b0, 12'd0, 1'b0);

    // fifth digit rejected, then back and clear
    key(1); key(2); key(3); key(4);
    e.err = 1'b1; e.val = exp_value; sb.push_back(e);
    key(5);
    chk("full_digits", {16'b0, digits}, 32'h1234);
    chk("full_count", {29'b0, count}, 32'd4);
    press('0, 1'b1, 1'b0);
    chk("back_digits", {16'b0, digits}, 32'h0123);
    chk("back_count", {29'b0, count}, 32'd3);
    press('0, 1'b0, 1'b1);
    chk("clr_digits", {16'b0, digits}, 32'd0);
    chk("clr_count", {29'b0, count}, 32'd0);
    press('0, 1'b1, 1'b0);
    chk("back_empty_count", {29'b0, count}, 32'd0);

    // two digits at once rejected; back beats a simultaneous digit
    e.err = 1'b1; e.val = exp_value; sb.push_back(e);
    press(10'b00_0010_1000, 1'b0, 1'b0);
    chk("multi_count", {29'b0, count}, 32'd0);
    key(8);
    chk("one_digit", {16'b0, digits}, 32'h0008);
    press(10'b00_1000_0000, 1'b1, 1'b0);
    chk("bk_pri_count", {29'b0, count}, 32'd0);
    chk("bk_pri_digits", {16'b0, digits}, 32'd0);

    // empty enter converts to 0; digit during busy is dropped
    enter(1'b1, 12'd0, 1'b1);

    // reset mid-conversion aborts without a pulse
    key(9); key(9); key(9);
    @(negedge clk);
    pb_enter = 1'b1;
    repeat (2) @(negedge clk);
    pb_enter = 1'b0;
    wait_busy();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_digits", {16'b0, digits}, 32'd0);
    chk("abort_count", {29'b0, count}, 32'd0);
    chk("abort_value", {20'b0, value}, 32'd0);
    chk("abort_vv", {31'b0, value_valid}, 32'd0);
    chk("abort_err", {31'b0, entry_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_value = '0;
    repeat (8) @(negedge clk);
    chk("abort_idle", {31'b0, busy}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/time_entry_encoder.md
# time_entry_encoder

Converts pushbutton digit entry into a 12-bit binary time value, the inverse of the seven-segment decoder path. The user keys up to four decimal digits, edits them with back/clear, and presses enter. A multi-cycle BCD-to-binary conversion then produces `value` for loading the timer preset. The BCD entry buffer is exported so the existing decoder and seven-segment path can echo the digits while they are typed.

## Interface
- `NDIG`, default 4: maximum number of digits held in the entry buffer.
- `VW`, default 12: width of the binary result; results above 2^VW−1 = 4095 are rejected.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  asynchronous, active-high reset.
- `pb_digit`  in  10  raw buttons; bit d means decimal digit d.
- `pb_enter`  in  1  raw button: start conversion.
- `pb_back`  in  1  raw button: delete the last digit.
- `pb_clear`  in  1  raw button: empty the buffer.
- `digits`  out  16  BCD entry buffer; the least-significant nibble is the last digit typed.
- `count`  out  3  number of digits held, 0..4.
- `value`  out  12  last successfully converted time.
- `value_valid`  out  1  one-cycle pulse when `value` updates.
- `entry_err`  out  1  one-cycle pulse when a press is rejected or the result overflows.
- `busy`  out  1  high during the CONV and DONE states.

## Operation
- Every raw button passes through a synchronizer and rising-edge detector. In the rest of this document, "press" means the one-cycle internal edge pulse, not the raw level.
- FSM states: IDLE, CONV, DONE.

IDLE:
- Per cycle, only the highest-priority press acts. Priority is clear > back > enter > digit. Lower-priority presses in the same cycle are dropped silently.
- clear: `digits`=0, `count`=0.
- back, with `count`>0: `digits`<=`digits`>>4 and `count`−1. With `count`=0 it has no effect and raises no error.
- digit d, with exactly one digit pressed and `count`<4: `digits`<={`digits`[11:0],d} and `count`+1.
- Rejected digit presses pulse `entry_err` and leave the buffer unchanged:
  - `count`=4;
  - two or more digit presses in the same cycle.
- enter: load the conversion index i=3 and acc=0, then go to CONV. Enter with `count`=0 is legal and converts to 0.

CONV (exactly 4 cycles):
- Each cycle: acc <= acc*10 + `digits`[4i+3:4i], then i−1.
- acc is 14 bits wide (9999 fits), so no intermediate wrap.
- After the cycle with i=0, go to DONE.

DONE (1 cycle):
- If acc ≤ 4095: `value`<=acc[11:0] and pulse `value_valid`.
- Otherwise: pulse `entry_err` and hold `value`.
- In both cases: `digits`=0, `count`=0, then return to IDLE.

Other rules:
- All presses arriving in CONV or DONE are discarded. They are not queued and raise no error.
- `value` changes only in DONE on success, or on reset.

## Timing
- Reset values: `digits`=0, `count`=0, `value`=0, `value_valid`=0, `entry_err`=0, `busy`=0, FSM=IDLE, acc=0.
- Raw-button-to-press latency is fixed by the synchronizer/edge detector and is identical for all buttons.
- With an enter press in cycle E:
  - `busy` is high in cycles E+1..E+5.
  - `value`/`value_valid` (or `entry_err`) appear in cycle E+5.
  - `busy` is low in E+6, and a press in E+6 is accepted.
- A digit, back, or clear press in cycle P updates `digits`/`count` in cycle P+1.
- `entry_err` for a rejected press also appears in cycle P+1.
- `value_valid` and `entry_err` are never high in the same cycle, and each is high for exactly one cycle per event.
- Reset asserted mid-CONV aborts the conversion immediately: all outputs return to their reset values and no pulse is emitted.

## Structure
- Shared package holds:
  - the state enum (IDLE, CONV, DONE);
  - `NDIG`, `VW`;
  - `MAX_VALUE`=4095;
  - the BCD nibble width of 4.
- The existing `sync_edge_detect` is instantiated once per button (13 instances), with `nrst` driven from ~`reset`. No new sub-module is needed.
- The ×10 step is written as (acc<<3)+(acc<<1)+nibble. No multiplier.

## Test plan
- Press 1,2,3,4 then enter → `digits`=0x1234 and `count`=4 before enter; `value`=1234 (0x4D2) with `value_valid` in cycle E+5; then `digits`=0 and `count`=0.
- Press 4,0,9,6 then enter → `entry_err` pulse in cycle E+5, `value` holds its prior value, `value_valid` stays 0, buffer cleared.
- Press 1,2,3,4,5 → fifth press gives `entry_err` and `digits` remains 0x1234. Then back → `digits`=0x0123, `count`=3. Then clear → 0, 0.
- Press digits 3 and 5 in the same cycle → `entry_err`, `count` unchanged. Press back and 7 in the same cycle → back only acts.
- Enter with an empty buffer → `value`=0 with `value_valid`. A digit press during `busy` is ignored: `count` stays 0 after DONE.
- Press 9,9,9 then enter, and assert `reset` in cycle E+2 → all outputs at reset values, no `value_valid` or `entry_err` pulse.
